// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and defaults for the Booth multiplier sequencer
package booth_pkg;

    localparam int DEFAULT_N = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

    // Start-to-product latency of the sequential Booth multiplier core.
    function automatic int booth_lat(input int n);
        return n + 2;
    endfunction

endpackage

// File: rtl/booth_operand_fifo.sv
// rtl/booth_operand_fifo.sv - circular operand-pair FIFO with occupancy counter
module booth_operand_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/booth_mult_sequencer.sv
// rtl/booth_mult_sequencer.sv - issues buffered operand pairs to the Booth multiplier and captures products
module booth_mult_sequencer
    import booth_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int LAT   = booth_lat(N),
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_m,
    input  logic [N-1:0]   in_q,
    output logic           mul_start,
    output logic [N-1:0]   mul_m,
    output logic [N-1:0]   mul_q,
    input  logic [2*N-1:0] mul_p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_p
);

    localparam int CNT_W = $clog2(LAT + 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [2*N-1:0]   fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             load;
    logic             capture;
    logic             cnt_clr;
    logic             ov_clr;

    assign in_ready = !fifo_full && !rst;

    booth_operand_fifo #(
        .WIDTH (2 * N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .pop   (load),
        .wdata ({in_m, in_q}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
        cnt_clr    = 1'b0;
        ov_clr     = 1'b0;
        mul_start  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    load       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mul_start  = 1'b1;
                cnt_clr    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt == CNT_W'(LAT - 1)) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // Clearing out_valid on every handshake keeps mul_start away from a live result.
                if (out_valid && out_ready) begin
                    ov_clr = 1'b1;
                    if (!fifo_empty) begin
                        load       = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mul_m     <= '0;
            mul_q     <= '0;
            out_valid <= 1'b0;
            out_p     <= '0;
        end else begin
            state <= state_next;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                mul_m <= fifo_rdata[2*N-1:N];
                mul_q <= fifo_rdata[N-1:0];
            end
            if (capture) begin
                out_p     <= mul_p;
                out_valid <= 1'b1;
            end else if (ov_clr) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
